// File: rtl/ula_video_out.sv
// ula_video_out: registers Spectrum / ULA+ colour into RGB888 at the pixel rate and
// measures live raster geometry. Define ULA_VOUT_GEOM_EN to build the geometry counters.
module ula_video_out #(
    parameter logic [7:0] LVL_NORM   = 8'hCA,
    parameter logic [7:0] LVL_BRIGHT = 8'hFF,
    parameter int         GEOM_W     = 10
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_7mp,
    input  logic              ce_7mn,
    input  logic              mode512,
    input  logic              I,
    input  logic              R,
    input  logic              G,
    input  logic              B,
    input  logic              ulap_ena,
    input  logic              ulap_mono,
    input  logic [7:0]        ulap_color,
    input  logic              HSync,
    input  logic              VSync,
    input  logic              HBlank,
    input  logic              VBlank,
    output logic              ce_pix_out,
    output logic [7:0]        vid_r,
    output logic [7:0]        vid_g,
    output logic [7:0]        vid_b,
    output logic              vid_de,
    output logic              vid_hs,
    output logic              vid_vs,
    output logic              vid_hb,
    output logic              vid_vb,
    output logic [GEOM_W-1:0] line_len,
    output logic [GEOM_W-1:0] frame_lines,
    output logic              geom_valid,
    output logic              geom_stable
);

    logic       ce_pix;
    logic       blank;
    logic [7:0] lvl;
    logic [2:0] spec_bits;
    logic [7:0] spec_lvl [3];
    logic [2:0] ulap_r;
    logic [2:0] ulap_g;
    logic [1:0] ulap_b;
    logic [7:0] col_r;
    logic [7:0] col_g;
    logic [7:0] col_b;

    logic       ce_pix_out_q, ce_pix_out_d;
    logic [7:0] vid_r_q, vid_r_d;
    logic [7:0] vid_g_q, vid_g_d;
    logic [7:0] vid_b_q, vid_b_d;
    logic [4:0] timing_q, timing_d;

    assign ce_pix    = mode512 ? (ce_7mp | ce_7mn) : ce_7mn;
    assign blank     = HBlank | VBlank;
    assign lvl       = I ? LVL_BRIGHT : LVL_NORM;
    assign spec_bits = {R, G, B};
    assign ulap_g    = ulap_color[7:5];
    assign ulap_r    = ulap_color[4:2];
    assign ulap_b    = ulap_color[1:0];

    // Classic palette: index 2 = red, 1 = green, 0 = blue.
    for (genvar gi = 0; gi < 3; gi++) begin : g_spec_chan
        assign spec_lvl[gi] = spec_bits[gi] ? lvl : 8'h00;
    end

    always_comb begin
        col_r = 8'h00;
        col_g = 8'h00;
        col_b = 8'h00;
        if (blank) begin
            col_r = 8'h00;
        end else if (ulap_ena && ulap_mono) begin
            col_r = ulap_color;
            col_g = ulap_color;
            col_b = ulap_color;
        end else if (ulap_ena) begin
            // Bit replication spreads the 3/2-bit fields over the full 0..FF range.
            col_r = {ulap_r, ulap_r, ulap_r[2:1]};
            col_g = {ulap_g, ulap_g, ulap_g[2:1]};
            col_b = {ulap_b, ulap_b, ulap_b, ulap_b};
        end else begin
            col_r = spec_lvl[2];
            col_g = spec_lvl[1];
            col_b = spec_lvl[0];
        end
    end

    always_comb begin
        ce_pix_out_d = ce_pix;
        vid_r_d      = vid_r_q;
        vid_g_d      = vid_g_q;
        vid_b_d      = vid_b_q;
        timing_d     = timing_q;
        if (ce_pix) begin
            vid_r_d  = col_r;
            vid_g_d  = col_g;
            vid_b_d  = col_b;
            timing_d = {~blank, HSync, VSync, HBlank, VBlank};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ce_pix_out_q <= 1'b0;
            vid_r_q      <= 8'h00;
            vid_g_q      <= 8'h00;
            vid_b_q      <= 8'h00;
            timing_q     <= 5'b0;
        end else begin
            ce_pix_out_q <= ce_pix_out_d;
            vid_r_q      <= vid_r_d;
            vid_g_q      <= vid_g_d;
            vid_b_q      <= vid_b_d;
            timing_q     <= timing_d;
        end
    end

    assign ce_pix_out = ce_pix_out_q;
    assign vid_r      = vid_r_q;
    assign vid_g      = vid_g_q;
    assign vid_b      = vid_b_q;
    assign vid_de     = timing_q[4];
    assign vid_hs     = timing_q[3];
    assign vid_vs     = timing_q[2];
    assign vid_hb     = timing_q[1];
    assign vid_vb     = timing_q[0];

`ifdef ULA_VOUT_GEOM_EN
    localparam logic [GEOM_W-1:0] ONE = GEOM_W'(1);

    logic              hs_rise;
    logic              vs_rise;
    logic              hs_prev_q, hs_prev_d;
    logic              vs_prev_q, vs_prev_d;
    logic [GEOM_W-1:0] hacc_q, hacc_d;
    logic [GEOM_W-1:0] vacc_q, vacc_d;
    logic [GEOM_W-1:0] line_len_q, line_len_d;
    logic [GEOM_W-1:0] line_len_ref_q, line_len_ref_d;
    logic [GEOM_W-1:0] frame_lines_q, frame_lines_d;
    logic              vs_seen_q, vs_seen_d;
    logic              geom_valid_q, geom_valid_d;
    logic              geom_stable_q, geom_stable_d;

    assign hs_rise = HSync & ~hs_prev_q;
    assign vs_rise = VSync & ~vs_prev_q;

    always_comb begin
        hs_prev_d      = hs_prev_q;
        vs_prev_d      = vs_prev_q;
        hacc_d         = hacc_q;
        vacc_d         = vacc_q;
        line_len_d     = line_len_q;
        line_len_ref_d = line_len_ref_q;
        frame_lines_d  = frame_lines_q;
        vs_seen_d      = vs_seen_q;
        geom_valid_d   = geom_valid_q;
        geom_stable_d  = geom_stable_q;
        if (ce_7mn) begin
            hs_prev_d = HSync;
            vs_prev_d = VSync;
            if (hs_rise) begin
                line_len_d = hacc_q;
                hacc_d     = ONE;
            end else if (hacc_q != '1) begin
                hacc_d = hacc_q + ONE;
            end
            if (vs_rise) begin
                frame_lines_d  = vacc_q;
                vacc_d         = hs_rise ? ONE : '0;
                vs_seen_d      = 1'b1;
                geom_valid_d   = vs_seen_q;
                // Stable only when this frame repeats the previous frame's line count and length.
                geom_stable_d  = geom_valid_q && (vacc_q == frame_lines_q)
                                 && (line_len_q == line_len_ref_q);
                line_len_ref_d = line_len_q;
            end else if (hs_rise && (vacc_q != '1)) begin
                vacc_d = vacc_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_prev_q      <= 1'b0;
            vs_prev_q      <= 1'b0;
            hacc_q         <= '0;
            vacc_q         <= '0;
            line_len_q     <= '0;
            line_len_ref_q <= '0;
            frame_lines_q  <= '0;
            vs_seen_q      <= 1'b0;
            geom_valid_q   <= 1'b0;
            geom_stable_q  <= 1'b0;
        end else begin
            hs_prev_q      <= hs_prev_d;
            vs_prev_q      <= vs_prev_d;
            hacc_q         <= hacc_d;
            vacc_q         <= vacc_d;
            line_len_q     <= line_len_d;
            line_len_ref_q <= line_len_ref_d;
            frame_lines_q  <= frame_lines_d;
            vs_seen_q      <= vs_seen_d;
            geom_valid_q   <= geom_valid_d;
            geom_stable_q  <= geom_stable_d;
        end
    end

    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign geom_valid  = geom_valid_q;
    assign geom_stable = geom_stable_q;
`else
    assign line_len    = '0;
    assign frame_lines = '0;
    assign geom_valid  = 1'b0;
    assign geom_stable = 1'b0;
`endif

endmodule

// File: tb/tb_ula_video_out.sv
// Self-checking bench for ula_video_out: per-cycle pixel-path model plus directed
// literal checks of colours, pixel rate and raster geometry.
module tb_ula_video_out;

`ifdef ULA_VOUT_GEOM_EN
    localparam bit GEOM_ON = 1'b1;
`else
    localparam bit GEOM_ON = 1'b0;
`endif

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic       reset, ce_7mp, ce_7mn, mode512;
    logic       in_i, in_r, in_g, in_b, ulap_ena, ulap_mono;
    logic [7:0] ulap_color;
    logic       hsync, vsync, hblank, vblank;
    logic       ce_pix_out;
    logic [7:0] vid_r, vid_g, vid_b;
    logic       vid_de, vid_hs, vid_vs, vid_hb, vid_vb;
    logic [9:0] line_len, frame_lines;
    logic       geom_valid, geom_stable;

    int          n_chk = 0;
    int          n_fail = 0;
    bit          model_en = 1'b0;
    logic [29:0] m_out;
    int          pix_total = 0;

    ula_video_out dut (
        .clk_sys(clk_sys), .reset(reset), .ce_7mp(ce_7mp), .ce_7mn(ce_7mn),
        .mode512(mode512), .I(in_i), .R(in_r), .G(in_g), .B(in_b),
        .ulap_ena(ulap_ena), .ulap_mono(ulap_mono), .ulap_color(ulap_color),
        .HSync(hsync), .VSync(vsync), .HBlank(hblank), .VBlank(vblank),
        .ce_pix_out(ce_pix_out), .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_hb(vid_hb), .vid_vb(vid_vb),
        .line_len(line_len), .frame_lines(frame_lines),
        .geom_valid(geom_valid), .geom_stable(geom_stable)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int gx(input int v);
        return GEOM_ON ? v : 0;
    endfunction

    // Expected RGB888 from the colour rules, using arithmetic rather than bit tricks.
    function automatic logic [23:0] model_rgb(input logic i, r, g, b, ena, mono,
                                              input logic [7:0] c, input logic blk);
        int lv, rr, gg, bb;
        if (blk) return 24'h0;
        if (ena && mono) return {c, c, c};
        if (ena) begin
            gg = (int'(c[7:5]) * 255 + 3) / 7;
            rr = (int'(c[4:2]) * 255 + 3) / 7;
            bb = int'(c[1:0]) * 85;
            return {8'(rr), 8'(gg), 8'(bb)};
        end
        lv = i ? 255 : 202;
        return {8'(r ? lv : 0), 8'(g ? lv : 0), 8'(b ? lv : 0)};
    endfunction

    initial begin : model_proc
        logic pix;
        forever begin
            @(posedge clk_sys);
            pix = mode512 ? (ce_7mp | ce_7mn) : ce_7mn;
            if (reset) begin
                m_out = '0;
            end else begin
                m_out[29] = pix;
                if (pix)
                    m_out[28:0] = {~(hblank | vblank), hsync, vsync, hblank, vblank,
                                   model_rgb(in_i, in_r, in_g, in_b, ulap_ena, ulap_mono,
                                             ulap_color, hblank | vblank)};
            end
        end
    end

    initial forever begin
        @(negedge clk_sys);
        if (model_en)
            check("pixel_path", {2'b00, ce_pix_out, vid_de, vid_hs, vid_vs, vid_hb, vid_vb,
                                 vid_r, vid_g, vid_b}, {2'b00, m_out});
    end

    initial forever begin
        @(negedge clk_sys);
        if (ce_pix_out === 1'b1) pix_total++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic zero_inputs();
        ce_7mp = 0; ce_7mn = 0; mode512 = 0;
        in_i = 0; in_r = 0; in_g = 0; in_b = 0;
        ulap_ena = 0; ulap_mono = 0; ulap_color = 8'h00;
        hsync = 0; vsync = 0; hblank = 0; vblank = 0;
    endtask

    // One 7 MHz period: ce_7mp then ce_7mn, four clk_sys each.
    task automatic pix_strobe();
        for (int p = 0; p < 4; p++) begin
            @(negedge clk_sys);
            ce_7mp = (p == 0);
            ce_7mn = (p == 2);
        end
    endtask

    task automatic run_lines(input int w, input int l, input int first, input int cnt);
        int ln;
        for (int n = 0; n < cnt; n++) begin
            ln = (first + n) % l;
            for (int hc = 0; hc < w; hc++) begin
                @(negedge clk_sys);
                ce_7mn = 1; ce_7mp = 0;
                hsync  = (hc >= 336) && (hc < 368);
                vsync  = (ln >= 8) && (ln < 10);
                hblank = (hc >= 256);
                vblank = (ln >= 6);
                {in_i, in_r, in_g, in_b} = 4'($urandom);
            end
        end
        @(negedge clk_sys);
        ce_7mn = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk_sys);
        zero_inputs();
        reset = 1;
        @(negedge clk_sys);
        reset = 0;
    endtask

    initial begin
        int base;
        zero_inputs();
        reset = 1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        model_en = 1;
        idle(2);
        check("reset_rgb", {vid_r, vid_g, vid_b}, 0);
        check("reset_ctl", {ce_pix_out, vid_de, vid_hs, vid_vs, vid_hb, vid_vb}, 0);
        check("reset_geom", {line_len, frame_lines, geom_valid, geom_stable}, 0);
        reset = 0;

        in_i = 1; in_r = 1; pix_strobe();
        check("bright_red", {vid_r, vid_g, vid_b, 7'b0, vid_de}, {24'hFF0000, 8'h01});
        in_i = 0; in_g = 1; in_b = 1; pix_strobe();
        check("norm_white", {vid_r, vid_g, vid_b}, 24'hCACACA);
        ulap_ena = 1; ulap_color = 8'hE3; pix_strobe();
        check("ulap_E3", {vid_r, vid_g, vid_b}, 24'h00FFFF);
        ulap_mono = 1; ulap_color = 8'h5A; pix_strobe();
        check("ulap_mono", {vid_r, vid_g, vid_b}, 24'h5A5A5A);
        ulap_ena = 0; ulap_mono = 0; in_i = 1; hblank = 1; pix_strobe();
        check("hblank_rgb", {vid_r, vid_g, vid_b}, 24'h000000);
        check("hblank_ctl", {vid_de, vid_hb}, 2'b01);
        hblank = 0; {in_i, in_r, in_g, in_b} = 4'b1000; pix_strobe();
        check("bright_black", {vid_r, vid_g, vid_b, 7'b0, vid_de}, {24'h000000, 8'h01});

        for (int m = 0; m < 2; m++) begin
            mode512 = (m == 1);
            idle(2);
            base = pix_total;
            repeat (448) pix_strobe();
            idle(2);
            check(m ? "rate_512" : "rate_256", pix_total - base, m ? 896 : 448);
        end

        for (int k = 0; k < 400; k++) begin
            @(negedge clk_sys);
            if (k % 100 == 0) mode512 = 1'($urandom);
            {in_i, in_r, in_g, in_b, ulap_ena, ulap_mono, hsync, vsync,
             hblank, vblank, ce_7mp, ce_7mn} = 12'($urandom);
            ulap_color = 8'($urandom);
        end

        pulse_reset();
        run_lines(448, 12, 0, 9);
        check("vs1_valid", geom_valid, 0);
        check("vs1_frame_lines", frame_lines, gx(8));
        run_lines(448, 12, 9, 12);
        check("vs2_line_len", line_len, gx(448));
        check("vs2_frame_lines", frame_lines, gx(312 - 300));
        check("vs2_status", {geom_valid, geom_stable}, gx(2));
        run_lines(448, 12, 9, 12);
        check("vs3_status", {geom_valid, geom_stable}, gx(3));
        run_lines(448, 12, 9, 3);
        run_lines(456, 11, 0, 9);
        check("switch_a_status", {geom_valid, geom_stable}, gx(2));
        check("switch_a_line_len", line_len, gx(456));
        run_lines(456, 11, 9, 11);
        check("switch_b_status", {geom_valid, geom_stable}, gx(2));
        check("switch_b_frame_lines", frame_lines, gx(11));
        run_lines(456, 11, 9, 11);
        check("switch_c_status", {geom_valid, geom_stable}, gx(3));

        run_lines(456, 11, 9, 2);
        @(negedge clk_sys);
        reset = 1;
        @(negedge clk_sys);
        check("midreset_geom", {line_len, frame_lines, geom_valid, geom_stable}, 0);
        check("midreset_vid", {ce_pix_out, vid_de, vid_r, vid_g, vid_b}, 0);
        reset = 0;
        run_lines(456, 11, 3, 6);
        check("midreset_vs1_valid", geom_valid, 0);
        run_lines(456, 11, 9, 11);
        check("midreset_vs2_status", {geom_valid, geom_stable}, gx(2));
        check("midreset_vs2_lines", frame_lines, gx(11));

        pulse_reset();
        for (int k = 0; k < 1101; k++) begin
            @(negedge clk_sys);
            ce_7mn = 1;
            hsync = (k == 1100);
        end
        @(negedge clk_sys);
        ce_7mn = 0;
        check("hacc_saturate", line_len, gx(1023));

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
